div_result_fifo: RTL
====================

Name: div_result_fifo

Overview:
- Downstream stage of the divider/modulo unit. Captures every result the divider emits (valid_out, result, plus the mode bit the result was computed under) into a small FIFO.
- Presents the buffered results to a consumer over a ready/valid handshake.
- The divider has no backpressure, so the block also tracks operations in flight. It drives a credit signal that tells the upstream issuer when it may start another divide without risking FIFO overflow.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- DATA_W, 32: result width; matches divider result.
- MAX_INFLIGHT, 8: maximum ops in flight inside the divider; sizes the in-flight counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted), released synchronously to clk by the system.
- issue  input  1  upstream starts an op in the divider this cycle (same cycle as divider valid_in=1).
- credit_ok  output  1  1 = upstream may issue this cycle.
- div_valid  input  1  divider valid_out.
- div_mode  input  1  mode of the returning op (0 = quotient, 1 = remainder).
- div_result  input  DATA_W  divider result.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_mode  output  1  mode bit of head entry.
- out_data  output  DATA_W  result of head entry.
- count  output  $clog2(DEPTH)+1  entries currently stored.
- overflow  output  1  sticky: a result was dropped.
- clear_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers, count and in-flight counter go to 0.
  - overflow=0, out_valid=0, credit_ok=1.
  - out_data and out_mode read as 0.
  - Storage contents are don't-care.
- Push: div_valid=1 and (count<DEPTH or pop this cycle) writes {div_mode, div_result} at the write pointer. The write pointer increments mod DEPTH.
- Pop: out_valid=1 and out_ready=1 advances the read pointer mod DEPTH.
- Head output:
  - out_valid = (count != 0).
  - out_data/out_mode = entry at the read pointer, driven combinationally from registered storage.
  - No same-cycle bypass: a push into an empty FIFO is visible on the next cycle, so latency is 1 cycle.
- Simultaneous push+pop:
  - count is unchanged.
  - Allowed when full: the pop frees the slot.
  - When empty, pop is impossible (out_valid=0), so only the push takes effect.
- Overflow: div_valid=1 while count==DEPTH and no pop → data dropped, overflow set to 1 next edge. It stays set until clear_ovf=1. If set and clear occur in the same cycle, set wins.
- count: +1 on push only, -1 on pop only; never exceeds DEPTH.
- In-flight counter:
  - +1 on issue, -1 on div_valid; issue and div_valid together → unchanged.
  - Saturates at 0: a div_valid with counter 0 is still pushed, and the counter holds at 0.
  - Saturates at MAX_INFLIGHT.
- Credit:
  - credit_ok = (count + inflight) < DEPTH and inflight < MAX_INFLIGHT.
  - Computed from registered state only; ignores same-cycle pop.
  - Upstream must not assert issue when credit_ok=0. An issue with credit_ok=0 still increments inflight (saturating).
- Wrap-around: both pointers wrap from DEPTH-1 to 0. Full/empty is distinguished by count, not by pointer compare.
- Reset mid-operation: all queued and in-flight bookkeeping is discarded. Results arriving after reset release are pushed normally with inflight held at 0.

Test Plan:
- Reset with DEPTH=4; push div_result=0x0000_0007, mode=0 at cycle 0 → out_valid=1, out_data=7, out_mode=0 at cycle 1; count=1; after pop, count=0 and out_valid=0.
- Push 100,200,300,400 with out_ready=0 → count=4, credit_ok=0; pop four times → data 100,200,300,400 in order, modes preserved; then push/pop 5 more entries to check pointer wrap.
- FIFO full (4 entries), div_valid=1 with out_ready=1 same cycle → count stays 4, new value appears after the three older ones, overflow=0.
- FIFO full, div_valid=1 with out_ready=0 → value dropped, overflow=1 next cycle; clear_ovf=1 → overflow=0; clear_ovf=1 with another drop same cycle → overflow stays 1.
- issue pulsed 3 cycles on empty FIFO → inflight=3, credit_ok=1; one more issue → credit_ok=0; one div_valid plus one pop → credit_ok returns to 1.
- Assert reset=0 asynchronously mid-clock with 2 entries queued and inflight=2 → out_valid=0, count=0, credit_ok=1, overflow=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/div_result_fifo.sv
// div_result_fifo: result buffer behind the divider/modulo unit.
// The divider cannot be stalled, so every returning result is captured into a
// small FIFO. The FIFO is drained by a ready/valid consumer. An in-flight
// counter plus the FIFO occupancy produce a credit, which keeps the issuer from
// starting a divide whose result would find no free slot.
module div_result_fifo #(
    parameter int DEPTH        = 8,   // power of two, >= 2
    parameter int DATA_W       = 32,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                     clk,
    input  logic                     reset,       // async, active low
    input  logic                     issue,
    output logic                     credit_ok,
    input  logic                     div_valid,
    input  logic                     div_mode,
    input  logic [DATA_W-1:0]        div_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_mode,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int SUM_W = ((CNT_W > IF_W) ? CNT_W : IF_W) + 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [IF_W-1:0]  MAX_IF_C  = IF_W'(MAX_INFLIGHT);
    localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);

    typedef struct packed {
        logic              mode;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IF_W-1:0]  inflight;
    logic [SUM_W-1:0] occupancy;

    logic full;
    logic pop;
    logic push;
    logic drop;

    // Full/empty come from count alone; the pointers are equal in both cases.
    assign full = (count == DEPTH_C);
    assign pop  = out_valid & out_ready;
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign push = div_valid & (~full | pop);
    assign drop = div_valid & full & ~pop;

    // Head is read straight from registered storage: no same-cycle bypass.
    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? head.data : '0;
    assign out_mode  = out_valid ? head.mode : 1'b0;

    // Credit looks at registered state only; a pop this cycle is not counted.
    assign occupancy = SUM_W'(count) + SUM_W'(inflight);
    assign credit_ok = (occupancy < DEPTH_SUM) && (inflight < MAX_IF_C);

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{mode: div_mode, data: div_result};
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy: push-only increments, pop-only decrements, both hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag; a new drop beats a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clear_ovf)
            overflow <= 1'b0;
    end

    // Ops inside the divider, saturating at both ends. A stray result after
    // reset still gets buffered but leaves the counter at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            unique case ({issue, div_valid})
                2'b10:   if (inflight != MAX_IF_C) inflight <= inflight + IF_W'(1);
                2'b01:   if (inflight != '0)       inflight <= inflight - IF_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
